// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   Writeback stage and 32-entry integer register file.
//   An execute result is captured into a one-entry writeback register (WBR).
//   One cycle later it is committed to the register array. Two combinational
//   read ports feed operands back into execute. They bypass the WBR over the
//   array. A 64-bit counter tracks retired instructions.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   wb_valid_i          execute result valid this cycle
//   inst_type_i         instruction type carried into the WBR
//   rd_w_ena_i          result writes a destination register
//   rd_w_addr_i         destination register index
//   rd_data_i           execute result
//   r1_r_ena_i/addr_i   read port 1 enable / index
//   r2_r_ena_i/addr_i   read port 2 enable / index
//   r1_data_o/r2_data_o read data (combinational)
//   commit_*_o          registered mirror of the WBR fields
//   instret_o           retired-instruction count
// ---------------------------------------------------------------------------
module wb_regfile #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid_i,
  input  logic [4:0]            inst_type_i,
  input  logic                  rd_w_ena_i,
  input  logic [ADDR_WIDTH-1:0] rd_w_addr_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic                  r1_r_ena_i,
  input  logic [ADDR_WIDTH-1:0] r1_r_addr_i,
  input  logic                  r2_r_ena_i,
  input  logic [ADDR_WIDTH-1:0] r2_r_addr_i,
  output logic [DATA_WIDTH-1:0] r1_data_o,
  output logic [DATA_WIDTH-1:0] r2_data_o,
  output logic                  commit_valid_o,
  output logic [4:0]            commit_type_o,
  output logic [ADDR_WIDTH-1:0] commit_rd_addr_o,
  output logic [DATA_WIDTH-1:0] commit_rd_data_o,
  output logic [63:0]           instret_o
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic                  wbr_valid_r;
  logic [4:0]            wbr_type_r;
  logic                  wbr_w_ena_r;
  logic [ADDR_WIDTH-1:0] wbr_addr_r;
  logic [DATA_WIDTH-1:0] wbr_data_r;
  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
  logic [63:0]           instret_r;
  logic                  commit_we_s;
  logic [DATA_WIDTH-1:0] r1_data_s;
  logic [DATA_WIDTH-1:0] r2_data_s;

  // The WBR writes the array only for a valid, writing result aimed at a nonzero index.
  assign commit_we_s = wbr_valid_r && wbr_w_ena_r && (wbr_addr_r != {ADDR_WIDTH{1'b0}});

  // Writeback register: loads every cycle; invalid results are zeroed so they cannot write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbr_valid_r <= 1'b0;
      wbr_type_r  <= 5'd0;
      wbr_w_ena_r <= 1'b0;
      wbr_addr_r  <= {ADDR_WIDTH{1'b0}};
      wbr_data_r  <= {DATA_WIDTH{1'b0}};
    end else if (wb_valid_i) begin
      wbr_valid_r <= 1'b1;
      wbr_type_r  <= inst_type_i;
      wbr_w_ena_r <= rd_w_ena_i;
      wbr_addr_r  <= rd_w_addr_i;
      wbr_data_r  <= rd_data_i;
    end else begin
      wbr_valid_r <= 1'b0;
      wbr_type_r  <= 5'd0;
      wbr_w_ena_r <= 1'b0;
      wbr_addr_r  <= {ADDR_WIDTH{1'b0}};
      wbr_data_r  <= {DATA_WIDTH{1'b0}};
    end
  end

  // Register array: cleared on reset, otherwise takes the committing WBR entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (commit_we_s) begin
      regs_r[wbr_addr_r] <= wbr_data_r;
    end else begin
      regs_r[0] <= {DATA_WIDTH{1'b0}};
    end
  end

  // Retired-instruction counter: counts every valid WBR entry, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_r <= 64'd0;
    end else if (wbr_valid_r) begin
      instret_r <= instret_r + 64'd1;
    end else begin
      instret_r <= instret_r;
    end
  end

  // Read port 1: disabled/x0 read zero, then the WBR bypass, then the array.
  always_comb begin
    r1_data_s = {DATA_WIDTH{1'b0}};
    if (!r1_r_ena_i) begin
      r1_data_s = {DATA_WIDTH{1'b0}};
    end else if (r1_r_addr_i == {ADDR_WIDTH{1'b0}}) begin
      r1_data_s = {DATA_WIDTH{1'b0}};
    end else if (wbr_valid_r && wbr_w_ena_r && (wbr_addr_r == r1_r_addr_i)) begin
      r1_data_s = wbr_data_r;
    end else begin
      r1_data_s = regs_r[r1_r_addr_i];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    r2_data_s = {DATA_WIDTH{1'b0}};
    if (!r2_r_ena_i) begin
      r2_data_s = {DATA_WIDTH{1'b0}};
    end else if (r2_r_addr_i == {ADDR_WIDTH{1'b0}}) begin
      r2_data_s = {DATA_WIDTH{1'b0}};
    end else if (wbr_valid_r && wbr_w_ena_r && (wbr_addr_r == r2_r_addr_i)) begin
      r2_data_s = wbr_data_r;
    end else begin
      r2_data_s = regs_r[r2_r_addr_i];
    end
  end

  assign r1_data_o        = r1_data_s;
  assign r2_data_o        = r2_data_s;
  assign commit_valid_o   = wbr_valid_r;
  assign commit_type_o    = wbr_type_r;
  assign commit_rd_addr_o = wbr_addr_r;
  assign commit_rd_data_o = wbr_data_r;
  assign instret_o        = instret_r;

endmodule
